imem_fetch_ctrl: RTL and testbench

//  Sequences the Fetch stage against a variable-latency instruction memory (req/ack handshake).

---
 rtl/imem_fetch_ctrl.sv | 178 +++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage sequencer for a variable-latency instruction memory using a req/ack handshake.
// It drives StallF/StallD/FlushD so that the PC and IF/ID registers advance only on valid words.
module imem_fetch_ctrl #(
    parameter int          TIMEOUT = 255,
    parameter int          CW      = 8,
    parameter logic [31:0] NOP     = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic        PCSrcD,
    input  logic        HazStallD,
    input  logic        ImemAck,
    input  logic [31:0] ImemRData,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    output logic [31:0] InstrF,
    output logic        InstrValidF,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FetchFault
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
        DISCARD,
        FAULT
    } fetchStateT;

    fetchStateT    state, stateNext;
    logic [31:0]   addrReg;
    logic [31:0]   holdBuf;
    logic [CW-1:0] waitCnt;
    logic          faultReg;

    logic          flushReq;
    logic          stallDEn;
    logic          loadBuf;
    logic          cntClr;
    logic          cntInc;
    logic          setFault;
    logic          timeoutHit;

    // The wait that would bring the count up to TIMEOUT is the last one allowed.
    assign timeoutHit = (waitCnt == CW'(TIMEOUT - 1));

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        stateNext   = state;
        ImemReq     = 1'b0;
        StallF      = 1'b1;
        flushReq    = 1'b1;
        stallDEn    = 1'b1;
        InstrValidF = 1'b0;
        InstrF      = NOP;
        loadBuf     = 1'b0;
        cntClr      = 1'b0;
        cntInc      = 1'b0;
        setFault    = 1'b0;

        case (state)
            IDLE: begin
                if (PCSrcD) begin
                    // A taken branch in Decode: let the PC load the target and fetch from there next cycle.
                    StallF = 1'b0;
                end else begin
                    stateNext = REQ;
                    cntClr    = 1'b1;
                end
            end

            REQ: begin
                ImemReq = 1'b1;
                if (PCSrcD) begin
                    StallF = 1'b0;
                    if (ImemAck) begin
                        stateNext = IDLE;
                    end else begin
                        stateNext = DISCARD;
                        cntClr    = 1'b1;
                    end
                end else if (ImemAck) begin
                    InstrF      = ImemRData;
                    InstrValidF = 1'b1;
                    flushReq    = 1'b0;
                    if (HazStallD) begin
                        loadBuf   = 1'b1;
                        stateNext = HOLD;
                    end else begin
                        StallF    = 1'b0;
                        stateNext = IDLE;
                    end
                end else if (timeoutHit) begin
                    setFault  = 1'b1;
                    stateNext = FAULT;
                end else begin
                    cntInc = 1'b1;
                end
            end

            HOLD: begin
                if (PCSrcD) begin
                    StallF    = 1'b0;
                    stateNext = IDLE;
                end else begin
                    InstrF      = holdBuf;
                    InstrValidF = 1'b1;
                    flushReq    = 1'b0;
                    if (!HazStallD) begin
                        StallF    = 1'b0;
                        stateNext = IDLE;
                    end
                end
            end

            DISCARD: begin
                // The wrong-path word is still owed by the memory; keep the request up and drop it on arrival.
                ImemReq = 1'b1;
                if (ImemAck) begin
                    stateNext = IDLE;
                end else if (timeoutHit) begin
                    setFault  = 1'b1;
                    stateNext = FAULT;
                end else begin
                    cntInc = 1'b1;
                end
            end

            FAULT: begin
                stallDEn = 1'b0;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign StallD     = stallDEn & HazStallD;
    assign FlushD     = flushReq & ~StallD;
    assign ImemAddr   = addrReg;
    assign FetchFault = faultReg;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            addrReg  <= '0;
            // NOTE: holdBuf is a single register, not a memory array, so it gets a defined reset value.
            holdBuf  <= NOP;
            waitCnt  <= '0;
            faultReg <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == IDLE) begin
                addrReg <= PCF & 32'hFFFF_FFFC;
            end
            if (loadBuf) begin
                holdBuf <= ImemRData;
            end
            if (cntClr) begin
                waitCnt <= '0;
            end else if (cntInc) begin
                waitCnt <= waitCnt + CW'(1);
            end
            if (setFault) begin
                faultReg <= 1'b1;
            end
        end
    end

    noFlushWhileStalled : assert property (@(posedge clk) disable iff (reset) !(FlushD && StallD));
    addrWordAligned     : assert property (@(posedge clk) disable iff (reset) ImemAddr[1:0] == 2'b00);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: one instance at the default timeout and one with TIMEOUT=4.
// Words the decoder should receive are queued as they are issued and compared when IF/ID accepts them.
module tb_imem_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, reset4;
    logic [31:0] PCF, ImemRData;
    logic        PCSrcD, HazStallD, ImemAck, ImemAck4;

    logic        ImemReq, InstrValidF, StallF, StallD, FlushD, FetchFault;
    logic [31:0] ImemAddr, InstrF;
    logic        ImemReq4, InstrValidF4, StallF4, StallD4, FlushD4, FetchFault4;
    logic [31:0] ImemAddr4, InstrF4;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];

    imem_fetch_ctrl u_dut (
        .clk(clk), .reset(reset), .PCF(PCF), .PCSrcD(PCSrcD), .HazStallD(HazStallD),
        .ImemAck(ImemAck), .ImemRData(ImemRData), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .InstrF(InstrF), .InstrValidF(InstrValidF), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FetchFault(FetchFault)
    );

    imem_fetch_ctrl #(.TIMEOUT(4)) u_dut4 (
        .clk(clk), .reset(reset4), .PCF(PCF), .PCSrcD(PCSrcD), .HazStallD(HazStallD),
        .ImemAck(ImemAck4), .ImemRData(ImemRData), .ImemReq(ImemReq4), .ImemAddr(ImemAddr4),
        .InstrF(InstrF4), .InstrValidF(InstrValidF4), .StallF(StallF4), .StallD(StallD4),
        .FlushD(FlushD4), .FetchFault(FetchFault4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A word enters IF/ID when it is valid and decode is not holding.
    always @(negedge clk) begin
        if (!reset && InstrValidF && !StallD) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL deliver_unexpected observed=0x%08h expected=none", InstrF);
            end
            if (sb.size() != 0) check("deliver", InstrF, sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; reset4 = 1'b1; PCF = '0; PCSrcD = 1'b0; HazStallD = 1'b0;
        ImemAck = 1'b0; ImemAck4 = 1'b0; ImemRData = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_req", ImemReq, 0);
        check("rst_addr", ImemAddr, 0);
        check("rst_stallf", StallF, 1);
        check("rst_flushd", FlushD, 1);
        check("rst_stalld", StallD, 0);
        check("rst_valid", InstrValidF, 0);
        check("rst_instr", InstrF, NOP);
        check("rst_fault", FetchFault, 0);

        // 1: ack in the first REQ cycle
        tick();
        ImemAck = 1'b1; ImemRData = 32'h0050_0093; sb.push_back(32'h0050_0093);
        @(negedge clk);
        check("t1_req", ImemReq, 1);
        check("t1_addr", ImemAddr, 32'h0);
        check("t1_valid", InstrValidF, 1);
        check("t1_instr", InstrF, 32'h0050_0093);
        check("t1_stallf", StallF, 0);
        tick();
        ImemAck = 1'b0; PCF = 32'h104;

        // 2: ack latency 5, load-use stall in the middle of the wait
        @(negedge clk);
        check("t2_idle_req", ImemReq, 0);
        check("t2_idle_stallf", StallF, 1);
        check("t2_idle_flushd", FlushD, 1);
        tick();
        for (int i = 1; i <= 5; i++) begin
            HazStallD = (i == 3);
            if (i == 5) begin
                ImemAck = 1'b1; ImemRData = 32'h00A0_0113; sb.push_back(32'h00A0_0113);
            end
            @(negedge clk);
            check("t2_req", ImemReq, 1);
            check("t2_addr", ImemAddr, 32'h104);
            if (i < 5) begin
                check("t2_wait_stallf", StallF, 1);
                check("t2_wait_flushd", FlushD, (i == 3) ? 0 : 1);
                check("t2_wait_stalld", StallD, (i == 3) ? 1 : 0);
                check("t2_wait_valid", InstrValidF, 0);
            end else begin
                check("t2_ack_stallf", StallF, 0);
                check("t2_ack_flushd", FlushD, 0);
            end
            tick();
        end
        ImemAck = 1'b0; HazStallD = 1'b0; PCF = 32'h108;

        // 3: decode stalled when the word arrives; it is buffered and delivered later
        tick();
        ImemAck = 1'b1; ImemRData = 32'hDEAD_BEEF; HazStallD = 1'b1; sb.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        check("t3_ack_stalld", StallD, 1);
        check("t3_ack_stallf", StallF, 1);
        check("t3_ack_flushd", FlushD, 0);
        tick();
        ImemAck = 1'b0; ImemRData = '0;
        repeat (2) begin
            @(negedge clk);
            check("t3_hold_instr", InstrF, 32'hDEAD_BEEF);
            check("t3_hold_valid", InstrValidF, 1);
            check("t3_hold_stalld", StallD, 1);
            check("t3_hold_stallf", StallF, 1);
            check("t3_hold_req", ImemReq, 0);
            tick();
        end
        HazStallD = 1'b0;
        @(negedge clk);
        check("t3_rel_stallf", StallF, 0);
        check("t3_rel_stalld", StallD, 0);
        check("t3_rel_flushd", FlushD, 0);
        check("t3_rel_instr", InstrF, 32'hDEAD_BEEF);
        tick();
        PCF = 32'h10C;

        // 4: redirect while waiting, late wrong-path ack is dropped
        tick();
        @(negedge clk);
        check("t4_req", ImemReq, 1);
        check("t4_addr", ImemAddr, 32'h10C);
        tick();
        PCSrcD = 1'b1;
        @(negedge clk);
        check("t4_redir_stallf", StallF, 0);
        check("t4_redir_flushd", FlushD, 1);
        check("t4_redir_valid", InstrValidF, 0);
        tick();
        PCSrcD = 1'b0; PCF = 32'h200;
        @(negedge clk);
        check("t4_disc_req", ImemReq, 1);
        check("t4_disc_addr", ImemAddr, 32'h10C);
        check("t4_disc_stallf", StallF, 1);
        check("t4_disc_flushd", FlushD, 1);
        tick();
        ImemAck = 1'b1; ImemRData = 32'h1111_1111;
        @(negedge clk);
        check("t4_drop_valid", InstrValidF, 0);
        check("t4_drop_flushd", FlushD, 1);
        check("t4_drop_stallf", StallF, 1);
        tick();
        ImemAck = 1'b0;
        @(negedge clk);
        check("t4_idle_req", ImemReq, 0);
        tick();
        ImemAck = 1'b1; ImemRData = 32'h0000_0293; sb.push_back(32'h0000_0293);
        @(negedge clk);
        check("t4_new_addr", ImemAddr, 32'h200);
        tick();
        ImemAck = 1'b0; PCF = 32'h300;

        // 5: redirect in the same cycle as the ack
        tick();
        ImemAck = 1'b1; ImemRData = 32'h2222_2222; PCSrcD = 1'b1;
        @(negedge clk);
        check("t5_valid", InstrValidF, 0);
        check("t5_flushd", FlushD, 1);
        check("t5_stallf", StallF, 0);
        check("t5_instr", InstrF, NOP);
        tick();
        ImemAck = 1'b0; PCSrcD = 1'b0; PCF = 32'h400;
        @(negedge clk);
        check("t5_idle_req", ImemReq, 0);
        check("t5_idle_stallf", StallF, 1);
        tick();
        ImemAck = 1'b1; ImemRData = 32'h0010_0073; sb.push_back(32'h0010_0073);
        @(negedge clk);
        check("t5_new_addr", ImemAddr, 32'h400);
        tick();
        ImemAck = 1'b0; PCF = 32'h500;

        // Redirect while a buffered word is held: the buffer is dropped
        tick();
        ImemAck = 1'b1; ImemRData = 32'h3333_3333; HazStallD = 1'b1;
        @(negedge clk);
        check("th_ack_stalld", StallD, 1);
        tick();
        ImemAck = 1'b0; HazStallD = 1'b0; PCSrcD = 1'b1;
        @(negedge clk);
        check("th_redir_valid", InstrValidF, 0);
        check("th_redir_stallf", StallF, 0);
        check("th_redir_flushd", FlushD, 1);
        tick();
        PCSrcD = 1'b0; PCF = 32'h600;
        @(negedge clk);
        check("th_idle_req", ImemReq, 0);
        tick();
        ImemAck = 1'b1; ImemRData = 32'h4444_4444; sb.push_back(32'h4444_4444);
        @(negedge clk);
        check("th_new_addr", ImemAddr, 32'h600);
        tick();
        ImemAck = 1'b0; PCF = 32'h700;

        // Reset in the middle of a request drops ImemReq on the next cycle
        tick();
        @(negedge clk);
        check("rm_req", ImemReq, 1);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("rm_req_drop", ImemReq, 0);
        check("rm_fault", FetchFault, 0);

        // 6: timeout on the TIMEOUT=4 instance
        tick();
        reset4 = 1'b0; PCF = 32'h800;
        @(negedge clk);
        check("t6_idle_req", ImemReq4, 0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("t6_wait_req", ImemReq4, 1);
            check("t6_wait_fault", FetchFault4, 0);
            tick();
        end
        HazStallD = 1'b1;
        @(negedge clk);
        check("t6_fault", FetchFault4, 1);
        check("t6_fault_req", ImemReq4, 0);
        check("t6_fault_stallf", StallF4, 1);
        check("t6_fault_flushd", FlushD4, 1);
        check("t6_fault_stalld", StallD4, 0);
        tick();
        ImemAck4 = 1'b1; ImemRData = 32'h5555_5555;
        @(negedge clk);
        check("t6_late_valid", InstrValidF4, 0);
        check("t6_late_fault", FetchFault4, 1);
        tick();
        ImemAck4 = 1'b0; HazStallD = 1'b0; reset4 = 1'b1;
        tick();
        reset4 = 1'b0;
        @(negedge clk);
        check("t6_rst_fault", FetchFault4, 0);
        check("t6_rst_req", ImemReq4, 0);
        tick();
        ImemAck4 = 1'b1; ImemRData = 32'h6666_6666;
        @(negedge clk);
        check("t6_restart_req", ImemReq4, 1);
        check("t6_restart_addr", ImemAddr4, 32'h800);
        check("t6_restart_valid", InstrValidF4, 1);
        check("t6_restart_instr", InstrF4, 32'h6666_6666);
        check("t6_restart_stallf", StallF4, 0);
        tick();
        ImemAck4 = 1'b0;

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
